// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and data memory (slave).
interface mem_stage_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: wait-stated load/store with timeout, branch resolution
// with flush/redirect, and the registered write-back payload toward MEM/WB.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_in,
  input  logic [31:0] PC_plus_X_in,
  input  logic [31:0] ALU_result_in,
  input  logic        zero_in,
  input  logic [31:0] read_data2_in,
  input  logic [4:0]  rd_in,
  input  logic        branch_in,
  input  logic        jump_in,
  input  logic        memRead_in,
  input  logic        memWrite_in,
  input  logic        memToReg_in,
  input  logic        regWrite_in,
  input  logic        prediction_in,
  mem_stage_ctrl_if.master dmem,
  output logic        stall,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        wb_regWrite,
  output logic        mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regWrite_q, wb_regWrite_d;
  logic        mem_err_q, mem_err_d;

  logic        mem_op, misalign, req, stall_c, complete, err;
  logic        taken, mispredict;
  logic [31:0] pc_plus4;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req           = 1'b0;
    stall_c       = 1'b0;
    complete      = 1'b0;
    err           = 1'b0;
    mem_op        = memRead_in | memWrite_in;
    misalign      = ALU_result_in[1:0] != 2'b00;
    pc_plus4      = PC_in + 32'd4;
    taken         = jump_in | (branch_in & zero_in);
    mispredict    = (branch_in | jump_in) & (taken != prediction_in);

    unique case (state_q)
      IDLE: begin
        if (mem_op && !misalign) begin
          req = 1'b1;
          if (dmem.dmem_ready) begin
            complete = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = ACCESS;
            cnt_d   = 8'd1;
          end
        end else begin
          complete = 1'b1;
          err      = mem_op;
        end
      end
      ACCESS: begin
        // Ready wins over the timeout in the final allowed cycle.
        req = 1'b1;
        if (dmem.dmem_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == TO) begin
          complete = 1'b1;
          err      = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    wb_result_d   = wb_result_q;
    wb_rd_d       = wb_rd_q;
    wb_regWrite_d = 1'b0;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;
    mem_err_d     = 1'b0;

    if (complete) begin
      wb_rd_d       = rd_in;
      wb_regWrite_d = regWrite_in & ~err;
      mem_err_d     = err;
      if (err && memRead_in)
        wb_result_d = ERR_DATA;
      else if (memToReg_in)
        wb_result_d = dmem.dmem_rdata;
      else if (jump_in)
        wb_result_d = pc_plus4;
      else
        wb_result_d = ALU_result_in;
      if (mispredict) begin
        flush_d       = 1'b1;
        redirect_pc_d = taken ? PC_plus_X_in : pc_plus4;
      end
    end
  end

  // Gated with rst_n so a request in flight is withdrawn the instant reset asserts.
  assign dmem.dmem_req   = req & rst_n;
  assign dmem.dmem_we    = req & rst_n & memWrite_in;
  assign dmem.dmem_addr  = ALU_result_in;
  assign dmem.dmem_wdata = read_data2_in;
  assign stall           = stall_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      wb_result_q   <= '0;
      wb_rd_q       <= '0;
      wb_regWrite_q <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      wb_result_q   <= wb_result_d;
      wb_rd_q       <= wb_rd_d;
      wb_regWrite_q <= wb_regWrite_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign wb_result   = wb_result_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regWrite = wb_regWrite_q;
  assign mem_err     = mem_err_q;

endmodule
